// File: rtl/blender_pkg.sv
// Shared types, sizing constants and helpers for the block blender.
package blender_pkg;

  typedef enum logic [1:0] {
    LOAD_P,
    DIVIDE,
    COEF,
    BLEND
  } state_t;

  localparam int MAX_M     = 72;
  localparam int MAX_BLOCK = MAX_M * MAX_M;
  localparam int SUM_W     = 21;
  localparam int ADDR_W    = 13;
  localparam int COEF_W    = 8;
  localparam int DATA_W    = 8;

  // Clip a 9-bit blend result to the 8-bit pixel range.
  function automatic logic [7:0] sat8(input logic [8:0] v);
    return v[8] ? 8'hFF : v[7:0];
  endfunction

endpackage

// File: rtl/pixel_buffer.sv
// Single-port synchronous block buffer, one-cycle read latency.
module pixel_buffer #(
  parameter int Depth      = 5184,
  parameter int Width      = 8,
  parameter int Addr_Width = 13
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [Addr_Width-1:0] addr,
  input  logic [Width-1:0]      wdata,
  output logic [Width-1:0]      rdata
);

  logic [Width-1:0] mem [Depth];

  // Write on enable; the read port always returns the addressed word next cycle.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/block_blender.sv
// Buffers a primary block, derives its mean and alpha/beta, then blends
// each watermark pixel with the matching primary pixel.
module block_blender
  import blender_pkg::*;
#(
  parameter int Data_Depth     = DATA_W,
  parameter int Block_Depth    = 7,
  parameter int Max_Block_Size = MAX_BLOCK,
  parameter int Addr_Width     = ADDR_W,
  parameter int Sum_Width      = SUM_W,
  parameter int Coef_Width     = COEF_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            cfg_m,
  input  logic [7:0]            cfg_amin,
  input  logic [7:0]            cfg_amax,
  input  logic [7:0]            cfg_bmin,
  input  logic [7:0]            cfg_bmax,
  input  logic                  in_valid,
  input  logic [Data_Depth-1:0] in_pixel,
  output logic                  in_ready,
  output logic [Data_Depth-1:0] Pixel_Data,
  output logic                  new_pixel,
  output logic                  block_done
);

  state_t                 state;
  logic [Block_Depth-1:0] m_r, m_eff;
  logic [Addr_Width-1:0]  m_ext, npix, k;
  logic [Sum_Width-1:0]   sum;
  logic [Addr_Width-1:0]  rem, rem_nx;
  logic [Addr_Width:0]    rem_sh;
  logic                   qbit;
  logic [4:0]             div_cnt;
  logic [Coef_Width-1:0]  amin_r, amax_r, bmin_r, bmax_r, alpha, beta;
  logic [Coef_Width-1:0]  da, db, alpha_nx, beta_nx;
  logic [7:0]             mean;
  logic                   xfer, last_k, we;
  logic [Data_Depth-1:0]  rd_data, w1;
  logic                   v1, last1;
  logic [8:0]             blend_sh;

  assign xfer   = in_valid & in_ready;
  assign m_ext  = Addr_Width'(m_eff);
  assign npix   = m_ext * m_ext;
  assign last_k = (k == npix - Addr_Width'(1));
  assign we     = xfer && (state == LOAD_P);

  // Block side: live (clamped) cfg_m on the first primary pixel, latched value afterwards,
  // so Npix is already correct for a 1x1 block's only transfer.
  always_comb begin
    m_eff = m_r;
    if (state == LOAD_P && k == '0) begin
      if (cfg_m == '0)              m_eff = Block_Depth'(1);
      else if (cfg_m > 8'(MAX_M))   m_eff = Block_Depth'(MAX_M);
      else                          m_eff = Block_Depth'(cfg_m);
    end
  end

  // Restoring divider step; the sum register shifts out dividend bits and collects quotient bits.
  always_comb begin
    rem_sh = {rem, sum[Sum_Width-1]};
    qbit   = (rem_sh >= {1'b0, npix});
    rem_nx = qbit ? Addr_Width'(rem_sh - {1'b0, npix}) : rem_sh[Addr_Width-1:0];
  end

  // Mean and coefficient arithmetic; an inverted range contributes no delta.
  always_comb begin
    mean     = (|sum[Sum_Width-1:8]) ? 8'hFF : sum[7:0];
    da       = (amax_r >= amin_r) ? amax_r - amin_r : '0;
    db       = (bmax_r >= bmin_r) ? bmax_r - bmin_r : '0;
    alpha_nx = amin_r + Coef_Width'(((2*Coef_Width)'(da) * (2*Coef_Width)'(mean)) >> 8);
    beta_nx  = bmax_r - Coef_Width'(((2*Coef_Width)'(db) * (2*Coef_Width)'(mean)) >> 8);
    blend_sh = 9'((17'(alpha) * 17'(rd_data) + 17'(beta) * 17'(w1)) >> 8);
  end

  pixel_buffer #(
    .Depth      (Max_Block_Size),
    .Width      (Data_Depth),
    .Addr_Width (Addr_Width)
  ) u_buf (
    .clk   (clk),
    .we    (we),
    .addr  (k),
    .wdata (in_pixel),
    .rdata (rd_data)
  );

  // Control FSM with registered handshake/outputs and the blend pipeline stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= LOAD_P;
      m_r        <= '0;
      k          <= '0;
      sum        <= '0;
      rem        <= '0;
      div_cnt    <= '0;
      amin_r     <= '0;
      amax_r     <= '0;
      bmin_r     <= '0;
      bmax_r     <= '0;
      alpha      <= '0;
      beta       <= '0;
      w1         <= '0;
      v1         <= 1'b0;
      last1      <= 1'b0;
      in_ready   <= 1'b0;
      Pixel_Data <= '0;
      new_pixel  <= 1'b0;
      block_done <= 1'b0;
    end else begin
      new_pixel  <= 1'b0;
      block_done <= 1'b0;
      v1         <= 1'b0;
      last1      <= 1'b0;
      case (state)
        LOAD_P: begin
          in_ready <= 1'b1;
          if (xfer) begin
            if (k == '0) begin
              m_r    <= m_eff;
              amin_r <= Coef_Width'(cfg_amin);
              amax_r <= Coef_Width'(cfg_amax);
              bmin_r <= Coef_Width'(cfg_bmin);
              bmax_r <= Coef_Width'(cfg_bmax);
            end
            sum <= sum + Sum_Width'(in_pixel);
            if (last_k) begin
              state    <= DIVIDE;
              k        <= '0;
              in_ready <= 1'b0;
              rem      <= '0;
              div_cnt  <= '0;
            end else begin
              k <= k + Addr_Width'(1);
            end
          end
        end
        DIVIDE: begin
          sum     <= {sum[Sum_Width-2:0], qbit};
          rem     <= rem_nx;
          div_cnt <= div_cnt + 5'd1;
          if (div_cnt == 5'(Sum_Width - 1)) state <= COEF;
        end
        COEF: begin
          alpha    <= alpha_nx;
          beta     <= beta_nx;
          state    <= BLEND;
          in_ready <= 1'b1;
        end
        BLEND: begin
          if (xfer) begin
            v1 <= 1'b1;
            w1 <= in_pixel;
            if (last_k) begin
              last1    <= 1'b1;
              in_ready <= 1'b0;
              k        <= '0;
            end else begin
              k <= k + Addr_Width'(1);
            end
          end
          if (v1) begin
            Pixel_Data <= sat8(blend_sh);
            new_pixel  <= 1'b1;
            if (last1) begin
              block_done <= 1'b1;
              state      <= LOAD_P;
              sum        <= '0;
            end
          end
        end
        default: state <= LOAD_P;
      endcase
    end
  end

endmodule

// File: tb/tb_block_blender.sv
// Directed bench for block_blender: hand-computed blocks plus a formula
// model for the large and randomised blocks.
module tb_block_blender;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cfg_m, cfg_amin, cfg_amax, cfg_bmin, cfg_bmax;
  logic       in_valid;
  logic [7:0] in_pixel;
  logic       in_ready;
  logic [7:0] Pixel_Data;
  logic       new_pixel;
  logic       block_done;

  block_blender dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_m      (cfg_m),
    .cfg_amin   (cfg_amin),
    .cfg_amax   (cfg_amax),
    .cfg_bmin   (cfg_bmin),
    .cfg_bmax   (cfg_bmax),
    .in_valid   (in_valid),
    .in_pixel   (in_pixel),
    .in_ready   (in_ready),
    .Pixel_Data (Pixel_Data),
    .new_pixel  (new_pixel),
    .block_done (block_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int data;
    bit last;
    int acc;
    int npix;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   blk_strobes = 0;
  int   acc_cyc = 0;
  bit   hung = 1'b0;
  int   p_arr[5184];
  int   w_arr[5184];

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst) begin
      if (new_pixel) begin
        if (exp_q.size() == 0) begin
          check_val("spurious_strobe", int'(new_pixel), 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_val("pixel", int'(Pixel_Data), e.data);
          check_val("latency", cyc - e.acc, 2);
          check_val("block_done", int'(block_done), int'(e.last));
          blk_strobes++;
          if (e.last) begin
            check_val("strobes_per_block", blk_strobes, e.npix);
            blk_strobes = 0;
          end
        end
      end else if (block_done) begin
        check_val("done_without_strobe", int'(new_pixel), 1);
      end
    end
  end

  task automatic push_px(input int px, input bit gaps, output int stalls);
    int waited = 0;
    bit ok = 1'b0;
    stalls = 0;
    if (hung) return;
    while (!ok && waited < 400) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        waited++;
      end else begin
        in_valid = 1'b1;
        in_pixel = 8'(px);
        if (in_ready) begin
          ok = 1'b1;
          acc_cyc = cyc;
        end else begin
          stalls++;
          waited++;
        end
      end
    end
    if (!ok) begin
      check_val("accept_timeout", int'(in_ready), 1);
      hung = 1'b1;
    end
  endtask

  task automatic send_block(input int cfgm, input int amin, input int amax,
                            input int bmin, input int bmax, input bit gaps,
                            input bit scramble, input int fixed_exp, input bit abort);
    int meff, npix, sum, mean, da, db, alpha, beta, st, v;
    exp_t e;
    meff = (cfgm == 0) ? 1 : ((cfgm > 72) ? 72 : cfgm);
    npix = meff * meff;
    sum = 0;
    for (int k = 0; k < npix; k++) sum += p_arr[k];
    mean = sum / npix;
    if (mean > 255) mean = 255;
    da = (amax >= amin) ? amax - amin : 0;
    db = (bmax >= bmin) ? bmax - bmin : 0;
    alpha = amin + ((da * mean) >> 8);
    beta  = bmax - ((db * mean) >> 8);
    cfg_m = 8'(cfgm);
    cfg_amin = 8'(amin);
    cfg_amax = 8'(amax);
    cfg_bmin = 8'(bmin);
    cfg_bmax = 8'(bmax);
    for (int k = 0; k < npix; k++) begin
      push_px(p_arr[k], gaps, st);
      if (scramble && k == 1) begin
        cfg_m    = 8'($urandom_range(1, 9));
        cfg_amin = 8'($urandom_range(0, 255));
        cfg_amax = 8'($urandom_range(0, 255));
        cfg_bmin = 8'($urandom_range(0, 255));
        cfg_bmax = 8'($urandom_range(0, 255));
      end
    end
    for (int k = 0; k < npix; k++) begin
      push_px(w_arr[k], gaps, st);
      if (hung) return;
      if (k == 0 && !gaps) check_val("ready_low_cycles", st, 22);
      if (fixed_exp >= 0) begin
        v = fixed_exp;
      end else begin
        v = (alpha * p_arr[k] + beta * w_arr[k]) >> 8;
        if (v > 255) v = 255;
      end
      e.data = v;
      e.last = (k == npix - 1);
      e.acc  = acc_cyc;
      e.npix = npix;
      exp_q.push_back(e);
    end
    if (abort) begin
      #1 rst = 1'b0;
      #1;
      check_val("strobes_before_reset", blk_strobes, 2);
      check_val("rst_new_pixel", int'(new_pixel), 0);
      check_val("rst_block_done", int'(block_done), 0);
      check_val("rst_pixel_data", int'(Pixel_Data), 0);
      check_val("rst_in_ready", int'(in_ready), 0);
      exp_q.delete();
      blk_strobes = 0;
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    check_val("ready_after_last_wm", int'(in_ready), 0);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val("drain", exp_q.size(), 0);
  endtask

  task automatic fill(input int pv, input int wv);
    for (int k = 0; k < 5184; k++) begin
      p_arr[k] = pv;
      w_arr[k] = wv;
    end
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    in_pixel = '0;
    cfg_m = '0;
    cfg_amin = '0;
    cfg_amax = '0;
    cfg_bmin = '0;
    cfg_bmax = '0;
    repeat (3) @(negedge clk);
    check_val("reset_in_ready", int'(in_ready), 0);
    check_val("reset_new_pixel", int'(new_pixel), 0);
    check_val("reset_pixel_data", int'(Pixel_Data), 0);
    check_val("reset_block_done", int'(block_done), 0);
    rst = 1'b1;
    @(negedge clk);
    check_val("ready_after_release", int'(in_ready), 1);

    // M=2 flat block: mean 100, alpha 177, beta 39 -> 99
    fill(100, 200);
    send_block(2, 128, 255, 0, 64, 1'b0, 1'b0, 99, 1'b0);
    wait_drain();

    // M=3 ramp: mean 4, alpha 0, beta 255 -> 10*255>>8 = 9
    fill(0, 10);
    for (int k = 0; k < 9; k++) p_arr[k] = k;
    send_block(3, 0, 0, 255, 255, 1'b0, 1'b0, 9, 1'b0);
    wait_drain();

    // Saturation: 255*255*2>>8 = 508 -> 255
    fill(255, 255);
    send_block(2, 255, 255, 255, 255, 1'b0, 1'b0, 255, 1'b0);
    wait_drain();

    // cfg_m=0 -> 1x1: mean 77, alpha 76, beta 179 -> (5852+8950)>>8 = 57
    fill(77, 50);
    send_block(0, 0, 255, 0, 255, 1'b0, 1'b0, 57, 1'b0);
    wait_drain();

    // cfg_m=100 -> 72x72 full buffer
    for (int k = 0; k < 5184; k++) begin
      p_arr[k] = (k * 7) % 256;
      w_arr[k] = (k * 13 + 5) % 256;
    end
    send_block(100, 32, 224, 16, 200, 1'b0, 1'b0, -1, 1'b0);
    wait_drain();

    // Back-to-back blocks with valid gaps and cfg changed mid-block
    for (int k = 0; k < 25; k++) begin
      p_arr[k] = int'($urandom_range(0, 255));
      w_arr[k] = int'($urandom_range(0, 255));
    end
    send_block(5, 200, 50, 30, 220, 1'b1, 1'b1, -1, 1'b0);
    for (int k = 0; k < 16; k++) begin
      p_arr[k] = int'($urandom_range(0, 255));
      w_arr[k] = int'($urandom_range(0, 255));
    end
    send_block(4, 10, 240, 250, 5, 1'b1, 1'b1, -1, 1'b0);
    wait_drain();

    // Reset during BLEND after two outputs, then a clean block
    fill(100, 200);
    send_block(2, 128, 255, 0, 64, 1'b0, 1'b0, 99, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    send_block(2, 128, 255, 0, 64, 1'b0, 1'b0, 99, 1'b0);
    wait_drain();
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
